// File: rtl/fa4_seq_ctrl.sv
// Wide adder built on one shared 4-bit ripple slice, one nibble per cycle.
// Define FA4_SEQ_CTRL_SUB_EN to add a sub port (a + ~b + ci subtraction).
module fa4_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef FA4_SEQ_CTRL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-5:0] res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;

  logic [4:0]       slice;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] acc;

`ifdef FA4_SEQ_CTRL_SUB_EN
  assign b_in = sub ? ~b : b;
`else
  assign b_in = b;
`endif

  assign slice = {1'b0, a_q[3:0]}
               + {1'b0, b_q[3:0]}
               + {4'b0, carry_q};

  // newest nibble enters at the top; the full word is ready on the last pass
  assign acc = {slice[3:0], res_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    s_d     = s_q;
    co_d    = co_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_in;
          carry_d = ci;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = slice[4];
        res_d   = acc[WIDTH-1:4];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          s_d     = acc;
          co_d    = slice[4];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      co_q    <= co_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign s         = s_q;
  assign co        = co_q;

endmodule

// File: tb/tb_fa4_seq_ctrl.sv
// Scoreboard bench for fa4_seq_ctrl: a 16-bit and an 8-bit instance.
// Subtraction cases are exercised when FA4_SEQ_CTRL_SUB_EN is defined.
module tb_fa4_seq_ctrl;

  localparam int W  = 16;
  localparam int NS = W / 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ci = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic         co;
  logic         busy;
`ifdef FA4_SEQ_CTRL_SUB_EN
  logic         sub_r = 1'b0;
`endif

  logic       iv8 = 1'b0;
  logic       ir8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       ci8 = 1'b0;
  logic       ov8;
  logic       or8 = 1'b1;
  logic [7:0] s8;
  logic       co8;
  logic       busy8;

  logic [W:0] sb[$];
  logic [8:0] sb8[$];
  int checks = 0;
  int errors = 0;
  int acc_cyc = 0;

  fa4_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci),
`ifdef FA4_SEQ_CTRL_SUB_EN
    .sub(sub_r),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .busy(busy)
  );

  fa4_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .ci(ci8),
`ifdef FA4_SEQ_CTRL_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(ov8), .out_ready(or8),
    .s(s8), .co(co8), .busy(busy8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] model(
    input logic [W-1:0] av,
    input logic [W-1:0] bv,
    input logic civ,
    input logic sv
  );
    logic [W-1:0] bb;
    bb = sv ? ~bv : bv;
    return {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, civ};
  endfunction

  task automatic accept(
    input logic [W-1:0] av,
    input logic [W-1:0] bv,
    input logic civ,
    input logic sv,
    input bit push
  );
    bit done = 0;
    in_valid = 1'b1;
    a  = av;
    b  = bv;
    ci = civ;
`ifdef FA4_SEQ_CTRL_SUB_EN
    sub_r = sv;
`endif
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) begin
        if (push) sb.push_back(model(av, bv, civ, sv));
        acc_cyc = cyc;
        done = 1;
      end
      tick();
    end
    in_valid = 1'b0;
    a  = W'($urandom);
    b  = W'($urandom);
    ci = 1'b1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout a=%h b=%h in_ready never 1", av, bv);
    end
  endtask

  task automatic get_result(input string nm);
    int n = 0;
    logic [W:0] exp_v;
    out_ready = 1'b1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s_timeout out_valid=0 required 1", nm);
      return;
    end
    checks++;
    if (n !== NS) begin
      errors++;
      $display("FAIL %s_latency got %0d required %0d", nm, n, NS);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb_empty unexpected result %h", nm, {co, s});
    end else begin
      exp_v = sb.pop_front();
      if ({co, s} !== exp_v) begin
        errors++;
        $display("FAIL %s_result got co=%b s=%h required co=%b s=%h",
                 nm, co, s, exp_v[W], exp_v[W-1:0]);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse out_valid=%b required 0", nm, out_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl rdy/ov/busy=%b required 000",
               {in_ready, out_valid, busy});
    end
    checks++;
    if ({co, s} !== '0 || {co8, s8} !== '0) begin
      errors++;
      $display("FAIL reset_out got %h/%h required 0", {co, s}, {co8, s8});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || ir8 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready=%b/%b required 1", in_ready, ir8);
    end
  endtask

  task automatic test_basic;
    accept(16'h1234, 16'h4321, 1'b0, 1'b0, 1);
    get_result("basic");
  endtask

  task automatic test_carry;
    accept(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
    get_result("carry_ripple");
    accept(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1);
    get_result("all_ones");
  endtask

  task automatic test_backpressure;
    int n = 0;
    logic [W:0] held;
    out_ready = 1'b0;
    accept(16'h1234, 16'h4321, 1'b0, 1'b0, 1);
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    held = sb.size() > 0 ? sb[0] : '0;
    in_valid = 1'b1;
    a  = 16'hAAAA;
    b  = 16'h1111;
    ci = 1'b1;
    repeat (10) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ctrl ov=%b rdy=%b required 1 0", out_valid, in_ready);
      end
      checks++;
      if ({co, s} !== held) begin
        errors++;
        $display("FAIL bp_hold got %h required %h", {co, s}, held);
      end
    end
    out_ready = 1'b1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL bp_sb_empty result %h", {co, s});
    end else if ({co, s} !== sb.pop_front()) begin
      errors++;
      $display("FAIL bp_result got %h required %h", {co, s}, held);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release ov=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    sb.push_back(model(16'hAAAA, 16'h1111, 1'b1, 1'b0));
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept busy=%b required 1", busy);
    end
    get_result("bp_held");
  endtask

  task automatic test_reset_mid;
    accept(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b000 || {co, s} !== '0) begin
      errors++;
      $display("FAIL mid_reset ov/busy/rdy=%b s=%h required 000 0",
               {out_valid, busy, in_ready}, {co, s});
    end
    rst = 1'b0;
    repeat (6) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_abort out_valid=%b required 0", out_valid);
      end
    end
    accept(16'h0010, 16'h0020, 1'b0, 1'b0, 1);
    get_result("after_reset");
  endtask

  task automatic test_back_to_back;
    int prev = 0;
    logic [W-1:0] av, bv;
    logic cv;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      av = W'($urandom);
      bv = W'($urandom);
      cv = 1'($urandom);
      accept(av, bv, cv, 1'b0, 1);
      if (i > 0) begin
        checks++;
        if (acc_cyc - prev !== NS + 2) begin
          errors++;
          $display("FAIL b2b_interval got %0d required %0d",
                   acc_cyc - prev, NS + 2);
        end
      end
      prev = acc_cyc;
      get_result("b2b");
    end
  endtask

  task automatic test_width8;
    int n = 0;
    logic [8:0] exp_v;
    iv8 = 1'b1;
    a8  = 8'h80;
    b8  = 8'h80;
    ci8 = 1'b0;
    checks++;
    if (ir8 !== 1'b1) begin
      errors++;
      $display("FAIL w8_ready in_ready=%b required 1", ir8);
    end
    sb8.push_back({1'b0, a8} + {1'b0, b8} + {8'b0, ci8});
    tick();
    iv8 = 1'b0;
    while (!ov8 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL w8_latency got %0d required 2", n);
    end
    exp_v = sb8.pop_front();
    checks++;
    if ({co8, s8} !== exp_v) begin
      errors++;
      $display("FAIL w8_result got %h required %h", {co8, s8}, exp_v);
    end
    tick();
    checks++;
    if (ov8 !== 1'b0) begin
      errors++;
      $display("FAIL w8_pulse out_valid=%b required 0", ov8);
    end
  endtask

`ifdef FA4_SEQ_CTRL_SUB_EN
  task automatic test_sub;
    accept(16'h0005, 16'h0007, 1'b1, 1'b1, 1);
    get_result("sub_neg");
    accept(16'h0007, 16'h0005, 1'b1, 1'b1, 1);
    get_result("sub_pos");
    accept(16'h1234, 16'h4321, 1'b0, 1'b0, 1);
    get_result("sub_off");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_width8();
`ifdef FA4_SEQ_CTRL_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
